// File: rtl/bandai_mapper_pkg.sv
// Shared constants for the Bandai gen2 mapper: register map, window numbers
// and the unlock FSM state encoding.
package bandai_mapper_pkg;

  typedef enum logic [1:0] {
    ST_LOCK0  = 2'd0,
    ST_LOCK1  = 2'd1,
    ST_STREAM = 2'd2,
    ST_OPEN   = 2'd3
  } unlock_state_e;

  localparam logic [7:0] REG_LAO  = 8'hC0;
  localparam logic [7:0] REG_RAM  = 8'hC1;
  localparam logic [7:0] REG_ROM0 = 8'hC2;
  localparam logic [7:0] REG_WP   = 8'hCE;
  localparam logic [7:0] REG_LOCK = 8'hCF;

  localparam logic [3:0] WIN_RAM  = 4'd1;
  localparam logic [3:0] WIN_ROM0 = 4'd2;

endpackage

// File: rtl/bandai_unlock_seq.sv
// Two-key address unlock FSM followed by a fixed serial bitstream on SO.
// Reports open once the whole stream has been shifted out.
module bandai_unlock_seq
  import bandai_mapper_pkg::*;
#(
  parameter logic [7:0]  KEY0        = 8'h5A,
  parameter logic [7:0]  KEY1        = 8'hA5,
  parameter int          STREAM_LEN  = 18,
  parameter logic [31:0] STREAM_BITS = 32'({1'b0, 16'h28A0, 1'b0})
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] addr,
  input  logic       relock,
  output logic       open,
  output logic       so
);

  unlock_state_e state_q, state_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [5:0]    cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_LOCK0;
      shreg_q <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOCK0: if (addr == KEY0) state_d = ST_LOCK1;
      ST_LOCK1: if (addr == KEY1) begin
        state_d = ST_STREAM;
        shreg_d = STREAM_BITS;
        cnt_d   = 6'(STREAM_LEN);
      end
      ST_STREAM: begin
        shreg_d = {1'b1, shreg_q[31:1]};
        cnt_d   = cnt_q - 6'd1;
        if (cnt_d == 6'd0) state_d = ST_OPEN;
      end
      default: ;
    endcase
    // Relock beats any key match landing on the same edge.
    if (relock) begin
      state_d = ST_LOCK0;
      shreg_d = '1;
      cnt_d   = '0;
    end
  end

  assign open = (state_q == ST_OPEN);
  assign so   = (state_q == ST_STREAM) ? shreg_q[0] : 1'b1;

endmodule

// File: rtl/bandai_mapper_gen2.sv
// Bandai gen2 cartridge mapper: unlock gate, bank registers, bus window decode.
// Optional RAM_WP_EN adds a RAM write-protect register at CEh.
module bandai_mapper_gen2
  import bandai_mapper_pkg::*;
#(
  parameter int          NUM_ROM_BANKS = 2,
  parameter int          BANK_W        = 7,
  parameter logic [7:0]  KEY0          = 8'h5A,
  parameter logic [7:0]  KEY1          = 8'hA5,
  parameter int          STREAM_LEN    = 18,
  parameter logic [31:0] STREAM_BITS   = 32'({1'b0, 16'h28A0, 1'b0})
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CEn,
  input  logic              SSn,
  input  logic              OEn,
  input  logic              WEn,
  input  logic [7:0]        ADDR,
  inout  wire  [7:0]        DQ,
  output logic              SO,
  output logic              ROMCEn,
  output logic              RAMCEn,
  output logic [BANK_W-1:0] RADDR
);

  localparam logic [3:0] ROM_LAST = 4'(WIN_ROM0 + 4'(NUM_ROM_BANKS) - 4'd1);

  logic open, so_bit, relock;
  logic sel, rce;

  assign sel = ~(SSn & CEn);
  assign rce = SSn & ~CEn;

  bandai_unlock_seq #(
    .KEY0        (KEY0),
    .KEY1        (KEY1),
    .STREAM_LEN  (STREAM_LEN),
    .STREAM_BITS (STREAM_BITS)
  ) u_unlock (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .addr   (ADDR),
    .relock (relock),
    .open   (open),
    .so     (so_bit)
  );

  assign SO = RSTn ? so_bit : 1'bz;

  // WEn is asynchronous: two sync stages plus one more for edge detect.
  logic [2:0] wen_q, wen_d;
  logic       wen_rise, capture, commit;
  logic       cap_vld_q, cap_vld_d;
  logic [7:0] cap_addr_q, cap_addr_d, cap_data_q, cap_data_d;

  assign wen_d    = {wen_q[1:0], WEn};
  assign wen_rise = wen_q[1] & ~wen_q[2];
  assign capture  = open & sel & ~WEn;
  assign commit   = wen_rise & cap_vld_q;
  assign relock   = commit && (cap_addr_q == REG_LOCK) && (cap_data_q == 8'h00);

  always_comb begin
    cap_vld_d  = cap_vld_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    if (commit) cap_vld_d = 1'b0;
    if (capture) begin
      cap_vld_d  = 1'b1;
      cap_addr_d = ADDR;
      cap_data_d = DQ;
    end
  end

  logic [BANK_W-1:0]                    lao_q, lao_d, ram_bank_q, ram_bank_d;
  logic [NUM_ROM_BANKS-1:0][BANK_W-1:0] rom_bank_q, rom_bank_d;
`ifdef RAM_WP_EN
  logic wp_q, wp_d;
`endif

  always_comb begin
    lao_d      = lao_q;
    ram_bank_d = ram_bank_q;
    rom_bank_d = rom_bank_q;
`ifdef RAM_WP_EN
    wp_d       = wp_q;
`endif
    if (commit) begin
      if (cap_addr_q == REG_LAO) lao_d = cap_data_q[BANK_W-1:0];
      if (cap_addr_q == REG_RAM) ram_bank_d = cap_data_q[BANK_W-1:0];
      for (int i = 0; i < NUM_ROM_BANKS; i++)
        if (cap_addr_q == REG_ROM0 + 8'(i)) rom_bank_d[i] = cap_data_q[BANK_W-1:0];
`ifdef RAM_WP_EN
      if (cap_addr_q == REG_WP) wp_d = cap_data_q[0];
`endif
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wen_q      <= '1;
      cap_vld_q  <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      lao_q      <= '1;
      ram_bank_q <= '1;
      rom_bank_q <= '1;
`ifdef RAM_WP_EN
      wp_q       <= 1'b0;
`endif
    end else begin
      wen_q      <= wen_d;
      cap_vld_q  <= cap_vld_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      lao_q      <= lao_d;
      ram_bank_q <= ram_bank_d;
      rom_bank_q <= rom_bank_d;
`ifdef RAM_WP_EN
      wp_q       <= wp_d;
`endif
    end
  end

  // Readback: unmapped addresses leave the bus floating.
  logic       rd_en, rd_hit;
  logic [7:0] rd_data;

  assign rd_en = open & sel & ~OEn & WEn;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (ADDR == REG_LAO) begin
      rd_hit = 1'b1;
      rd_data[BANK_W-1:0] = lao_q;
    end
    if (ADDR == REG_RAM) begin
      rd_hit = 1'b1;
      rd_data[BANK_W-1:0] = ram_bank_q;
    end
    for (int i = 0; i < NUM_ROM_BANKS; i++)
      if (ADDR == REG_ROM0 + 8'(i)) begin
        rd_hit = 1'b1;
        rd_data[BANK_W-1:0] = rom_bank_q[i];
      end
    if (ADDR == REG_LOCK) rd_hit = 1'b1;
`ifdef RAM_WP_EN
    if (ADDR == REG_WP) begin
      rd_hit = 1'b1;
      rd_data[0] = wp_q;
    end
`endif
  end

  assign DQ = (rd_en & rd_hit) ? rd_data : 8'hzz;

  logic       ram_wr_block;
  logic [3:0] w;

  assign w = ADDR[7:4];
`ifdef RAM_WP_EN
  assign ram_wr_block = wp_q & ~WEn;
`else
  assign ram_wr_block = 1'b0;
`endif

  always_comb begin
    ROMCEn = 1'b1;
    RAMCEn = 1'b1;
    RADDR  = '0;
    if (open & rce) begin
      if (w == WIN_RAM) begin
        if (!ram_wr_block) begin
          RAMCEn = 1'b0;
          RADDR  = ram_bank_q;
        end
      end else if (w > ROM_LAST) begin
        ROMCEn = 1'b0;
        RADDR  = {lao_q[BANK_W-5:0], w};
      end else begin
        for (int i = 0; i < NUM_ROM_BANKS; i++)
          if (w == WIN_ROM0 + 4'(i)) begin
            ROMCEn = 1'b0;
            RADDR  = rom_bank_q[i];
          end
      end
    end
  end

endmodule

// File: tb/tb_bandai_mapper_gen2.sv
// Directed bench for bandai_mapper_gen2 (default parameters). DQ is pulled up
// and SO pulled down so a floating bus reads FFh and a floating SO reads 0.
module tb_bandai_mapper_gen2;

  localparam int BANK_W = 7;

  logic CLK = 1'b0;
  logic RSTn, CEn, SSn, OEn, WEn;
  logic [7:0] ADDR, dq_drv;
  logic dq_oe;
  tri1 [7:0] DQ;
  tri0 SO;
  logic ROMCEn, RAMCEn;
  logic [BANK_W-1:0] RADDR;

  int checks = 0;
  int failures = 0;

  assign DQ = dq_oe ? dq_drv : 8'hzz;

  always #5 CLK = ~CLK;

  bandai_mapper_gen2 dut (
    .CLK(CLK), .RSTn(RSTn), .CEn(CEn), .SSn(SSn), .OEn(OEn), .WEn(WEn),
    .ADDR(ADDR), .DQ(DQ), .SO(SO), .ROMCEn(ROMCEn), .RAMCEn(RAMCEn), .RADDR(RADDR)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    CEn = 1'b1; SSn = 1'b1; OEn = 1'b1; WEn = 1'b1; dq_oe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    ADDR = a; SSn = 1'b0; CEn = 1'b1; OEn = 1'b1;
    dq_drv = d; dq_oe = 1'b1; WEn = 1'b0;
    step(2);
    WEn = 1'b1; dq_oe = 1'b0; SSn = 1'b1;
    step(4);
  endtask

  task automatic rd_setup(input logic [7:0] a);
    ADDR = a; SSn = 1'b0; CEn = 1'b1; OEn = 1'b0; WEn = 1'b1; dq_oe = 1'b0;
  endtask

  task automatic rom_setup(input logic [7:0] a);
    ADDR = a; SSn = 1'b1; CEn = 1'b0; OEn = 1'b0; WEn = 1'b1; dq_oe = 1'b0;
  endtask

  task automatic do_unlock();
    ADDR = 8'h5A; step(1);
    ADDR = 8'hA5; step(1);
    ADDR = 8'h00; step(18);
  endtask

  task automatic test_reset();
    RSTn = 1'b0; idle_bus(); ADDR = 8'h20; CEn = 1'b0; dq_drv = 8'h00;
    #3;
    checks++; if (SO !== 1'b0) begin failures++; $display("FAIL reset_so_z got=%b exp=0(Z)", SO); end
    checks++; if (ROMCEn !== 1'b1 || RAMCEn !== 1'b1) begin failures++; $display("FAIL reset_ce got=%b%b exp=11", ROMCEn, RAMCEn); end
    checks++; if (RADDR !== 7'h00) begin failures++; $display("FAIL reset_raddr got=%h exp=00", RADDR); end
    checks++; if (DQ !== 8'hFF) begin failures++; $display("FAIL reset_dq_z got=%h exp=FF(Z)", DQ); end
    @(negedge CLK); RSTn = 1'b1;
    step(1);
    @(negedge CLK);
    checks++; if (SO !== 1'b1) begin failures++; $display("FAIL idle_so got=%b exp=1", SO); end
    checks++; if (ROMCEn !== 1'b1) begin failures++; $display("FAIL lock0_romce got=%b exp=1", ROMCEn); end
    step(1);
  endtask

  task automatic test_unlock_stream();
    logic [17:0] exp_so;
    exp_so = {1'b0, 16'h28A0, 1'b0};
    idle_bus();
    ADDR = 8'h5A; step(1);
    ADDR = 8'h33; step(1);
    ADDR = 8'hA5; step(1);
    rom_setup(8'h20);
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      checks++; if (SO !== exp_so[i]) begin failures++; $display("FAIL stream_so[%0d] got=%b exp=%b", i, SO, exp_so[i]); end
      checks++; if (ROMCEn !== 1'b1) begin failures++; $display("FAIL stream_romce[%0d] got=%b exp=1", i, ROMCEn); end
      step(1);
    end
    @(negedge CLK);
    checks++; if (ROMCEn !== 1'b0 || RADDR !== 7'h7F) begin failures++; $display("FAIL open_rom got=%b/%h exp=0/7f", ROMCEn, RADDR); end
    checks++; if (SO !== 1'b1) begin failures++; $display("FAIL open_so got=%b exp=1", SO); end
    step(1);
  endtask

  task automatic test_decode();
    wr(8'hC2, 8'h03);
    wr(8'hC0, 8'h05);
    rom_setup(8'h20); @(negedge CLK);
    checks++; if (ROMCEn !== 1'b0 || RAMCEn !== 1'b1 || RADDR !== 7'h03) begin failures++; $display("FAIL win2 got=%b%b/%h exp=01/03", ROMCEn, RAMCEn, RADDR); end
    rom_setup(8'h30); #1;
    checks++; if (ROMCEn !== 1'b0 || RADDR !== 7'h7F) begin failures++; $display("FAIL win3 got=%b/%h exp=0/7f", ROMCEn, RADDR); end
    rom_setup(8'h40); #1;
    checks++; if (ROMCEn !== 1'b0 || RADDR !== 7'h54) begin failures++; $display("FAIL win4_lao got=%b/%h exp=0/54", ROMCEn, RADDR); end
    rom_setup(8'hF7); #1;
    checks++; if (ROMCEn !== 1'b0 || RADDR !== 7'h5F) begin failures++; $display("FAIL winF_lao got=%b/%h exp=0/5f", ROMCEn, RADDR); end
    rom_setup(8'h10); #1;
    checks++; if (RAMCEn !== 1'b0 || ROMCEn !== 1'b1 || RADDR !== 7'h7F) begin failures++; $display("FAIL win1_ram got=%b%b/%h exp=01/7f", RAMCEn, ROMCEn, RADDR); end
    rom_setup(8'h05); #1;
    checks++; if (RAMCEn !== 1'b1 || ROMCEn !== 1'b1 || RADDR !== 7'h00) begin failures++; $display("FAIL win0 got=%b%b/%h exp=11/00", RAMCEn, ROMCEn, RADDR); end
    idle_bus(); step(1);
  endtask

  task automatic test_readback();
    wr(8'hC1, 8'hFF);
    rd_setup(8'hC1); @(negedge CLK);
    checks++; if (DQ !== 8'h7F) begin failures++; $display("FAIL rb_c1 got=%h exp=7f", DQ); end
    rd_setup(8'hC2); #1;
    checks++; if (DQ !== 8'h03) begin failures++; $display("FAIL rb_c2 got=%h exp=03", DQ); end
    rd_setup(8'hC0); #1;
    checks++; if (DQ !== 8'h05) begin failures++; $display("FAIL rb_c0 got=%h exp=05", DQ); end
    rd_setup(8'hCF); #1;
    checks++; if (DQ !== 8'h00) begin failures++; $display("FAIL rb_cf got=%h exp=00", DQ); end
    rd_setup(8'hC5); #1;
    checks++; if (DQ !== 8'hFF) begin failures++; $display("FAIL rb_unmapped got=%h exp=FF(Z)", DQ); end
    rd_setup(8'hC1); OEn = 1'b1; #1;
    checks++; if (DQ !== 8'hFF) begin failures++; $display("FAIL rb_oe_off got=%h exp=FF(Z)", DQ); end
    idle_bus(); step(1);
  endtask

  task automatic test_no_capture();
    // WEn pulse with no select, then a non-zero LOCK write: neither relocks.
    ADDR = 8'hCF; dq_drv = 8'h00; dq_oe = 1'b1; WEn = 1'b0;
    step(2);
    WEn = 1'b1; dq_oe = 1'b0; step(4);
    wr(8'hCF, 8'h01);
    rom_setup(8'h20); @(negedge CLK);
    checks++; if (ROMCEn !== 1'b0) begin failures++; $display("FAIL no_relock got=%b exp=0", ROMCEn); end
    idle_bus(); step(1);
  endtask

  task automatic test_wp();
    wr(8'hCE, 8'h01);
`ifdef RAM_WP_EN
    rd_setup(8'hCE); @(negedge CLK);
    checks++; if (DQ !== 8'h01) begin failures++; $display("FAIL rb_wp got=%h exp=01", DQ); end
    rom_setup(8'h10); WEn = 1'b0; OEn = 1'b1; #1;
    checks++; if (RAMCEn !== 1'b1 || RADDR !== 7'h00) begin failures++; $display("FAIL wp_block got=%b/%h exp=1/00", RAMCEn, RADDR); end
    WEn = 1'b1; OEn = 1'b0; #1;
    checks++; if (RAMCEn !== 1'b0 || RADDR !== 7'h7F) begin failures++; $display("FAIL wp_read got=%b/%h exp=0/7f", RAMCEn, RADDR); end
    step(4);
    wr(8'hCE, 8'h00);
`else
    rd_setup(8'hCE); @(negedge CLK);
    checks++; if (DQ !== 8'hFF) begin failures++; $display("FAIL rb_ce_unmapped got=%h exp=FF(Z)", DQ); end
    rom_setup(8'h10); WEn = 1'b0; OEn = 1'b1; #1;
    checks++; if (RAMCEn !== 1'b0) begin failures++; $display("FAIL ram_write_en got=%b exp=0", RAMCEn); end
    WEn = 1'b1; step(4);
`endif
    idle_bus(); step(1);
  endtask

  task automatic test_relock();
    wr(8'hCF, 8'h00);
    rom_setup(8'h20); @(negedge CLK);
    checks++; if (ROMCEn !== 1'b1) begin failures++; $display("FAIL relock_romce got=%b exp=1", ROMCEn); end
    rd_setup(8'hC1); #1;
    checks++; if (DQ !== 8'hFF) begin failures++; $display("FAIL relock_dq got=%h exp=FF(Z)", DQ); end
    step(1);
    // Second key alone must not open.
    idle_bus(); ADDR = 8'hA5; step(1); ADDR = 8'h00; step(20);
    rom_setup(8'h20); @(negedge CLK);
    checks++; if (ROMCEn !== 1'b1) begin failures++; $display("FAIL key1_only got=%b exp=1", ROMCEn); end
    step(1);
    idle_bus(); do_unlock();
    rom_setup(8'h20); @(negedge CLK);
    checks++; if (ROMCEn !== 1'b0 || RADDR !== 7'h03) begin failures++; $display("FAIL reunlock got=%b/%h exp=0/03", ROMCEn, RADDR); end
    idle_bus(); step(1);
  endtask

  task automatic test_reset_midstream();
    wr(8'hCF, 8'h00);
    ADDR = 8'h5A; step(1);
    ADDR = 8'hA5; step(1);
    ADDR = 8'h00; step(6);
    @(negedge CLK);
    checks++; if (SO !== 1'b1) begin failures++; $display("FAIL mid_so_bit6 got=%b exp=1", SO); end
    #1 RSTn = 1'b0;
    #1;
    checks++; if (SO !== 1'b0) begin failures++; $display("FAIL mid_reset_so got=%b exp=0(Z)", SO); end
    @(negedge CLK); RSTn = 1'b1;
    step(1);
    do_unlock();
    rd_setup(8'hC1); @(negedge CLK);
    checks++; if (DQ !== 8'h7F) begin failures++; $display("FAIL post_rst_c1 got=%h exp=7f", DQ); end
    rd_setup(8'hC2); #1;
    checks++; if (DQ !== 8'h7F) begin failures++; $display("FAIL post_rst_c2 got=%h exp=7f", DQ); end
    rd_setup(8'hC0); #1;
    checks++; if (DQ !== 8'h7F) begin failures++; $display("FAIL post_rst_c0 got=%h exp=7f", DQ); end
    idle_bus(); step(1);
  endtask

  initial begin
    test_reset();
    test_unlock_stream();
    test_decode();
    test_readback();
    test_no_capture();
    test_wp();
    test_relock();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
